// File: rtl/cpu_if_arbiter.sv
// cpu_if_arbiter: N-to-1 round-robin arbiter for the pulse-style CPU register
// interface. Each master owns one request slot. Pending slots are issued to the
// single slave one at a time. Each completion and its read data are returned to
// the master that issued the access.
//
// Optional feature: define CPU_IF_ARB_TIMEOUT_EN to abort an access the slave
// has not completed within TIMEOUT_CYCLES. The aborted access completes with
// error=1 and read data TIMEOUT_DATA. Without the macro there is no counter, and
// m_cpu_if_error is tied low.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   m_cpu_if_read/write          per-master request pulses (write wins when both)
//   m_cpu_if_write_data/address  flattened per-master request payload
//   m_cpu_if_read_data           per-master read data, held until next completion
//   m_cpu_if_access_complete     per-master completion pulse
//   m_cpu_if_error               qualifies completion: 1 = timed out
//   s_cpu_if_read/write          slave request pulses
//   s_cpu_if_write_data/address  held stable from issue until completion
//   s_cpu_if_read_data           slave read data, valid with access_complete
//   s_cpu_if_access_complete     slave completion pulse
module cpu_if_arbiter #(
   parameter int unsigned           NUM_MASTERS    = 2,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           ADDR_WIDTH     = 30,
   parameter int unsigned           TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 'hDEAD_BEEF
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [NUM_MASTERS-1:0]            m_cpu_if_read,
   input  logic [NUM_MASTERS-1:0]            m_cpu_if_write,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_cpu_if_write_data,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_cpu_if_address,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_cpu_if_read_data,
   output logic [NUM_MASTERS-1:0]            m_cpu_if_access_complete,
   output logic [NUM_MASTERS-1:0]            m_cpu_if_error,
   output logic                              s_cpu_if_read,
   output logic                              s_cpu_if_write,
   output logic [DATA_WIDTH-1:0]             s_cpu_if_write_data,
   output logic [ADDR_WIDTH-1:0]             s_cpu_if_address,
   input  logic [DATA_WIDTH-1:0]             s_cpu_if_read_data,
   input  logic                              s_cpu_if_access_complete
);

   localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [0:0]                             state_q, state_d;
   logic [IDX_W-1:0]                       ptr_q, ptr_d;
   logic [IDX_W-1:0]                       gnt_q, gnt_d;

   // Request slots
   logic [NUM_MASTERS-1:0]                 pend_q, pend_d;
   logic [NUM_MASTERS-1:0]                 is_wr_q, is_wr_d;
   logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] slot_addr_q, slot_addr_d;
   logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] slot_wdata_q, slot_wdata_d;

   // Registered outputs
   logic                                   s_read_q, s_read_d;
   logic                                   s_write_q, s_write_d;
   logic [ADDR_WIDTH-1:0]                  s_addr_q, s_addr_d;
   logic [DATA_WIDTH-1:0]                  s_wdata_q, s_wdata_d;
   logic [NUM_MASTERS-1:0]                 m_cmp_q, m_cmp_d;
   logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;

   logic                                   done;
   logic                                   arb_valid;
   logic [IDX_W-1:0]                       arb_idx;
   logic [IDX_W-1:0]                       cand;

`ifdef CPU_IF_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_MASTERS-1:0] m_err_q, m_err_d;
   logic                   expire;

   // cnt_q counts WAIT cycles since the grant edge, so TIMEOUT_CYCLES-1 means
   // this edge is TIMEOUT_CYCLES after the grant.
   assign expire = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0) ^ (TIMEOUT_DATA == '0);
`endif

   // Round-robin pick: first pending slot at or after the pointer, wrapping.
   always_comb begin
      arb_valid = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         cand = IDX_W'((32'(ptr_q) + k) % NUM_MASTERS);
         if (!arb_valid && pend_q[cand]) begin
            arb_valid = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      s_read_d  = 1'b0;
      s_write_d = 1'b0;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      m_cmp_d   = '0;
      m_rdata_d = m_rdata_q;
      done      = 1'b0;
`ifdef CPU_IF_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      m_err_d   = '0;
`endif

      unique case (state_q)
         ST_IDLE: begin
            // A slave completion seen here is spurious and is ignored.
            if (arb_valid) begin
               gnt_d     = arb_idx;
               s_read_d  = !is_wr_q[arb_idx];
               s_write_d = is_wr_q[arb_idx];
               s_addr_d  = slot_addr_q[arb_idx];
               s_wdata_d = slot_wdata_q[arb_idx];
               ptr_d     = IDX_W'((32'(arb_idx) + 1) % NUM_MASTERS);
               state_d   = ST_WAIT;
`ifdef CPU_IF_ARB_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         ST_WAIT: begin
`ifdef CPU_IF_ARB_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
            // A real completion takes priority over an expiry on the same edge.
            if (s_cpu_if_access_complete) begin
               done             = 1'b1;
               m_cmp_d[gnt_q]   = 1'b1;
               m_rdata_d[gnt_q] = s_cpu_if_read_data;
               state_d          = ST_IDLE;
            end
`ifdef CPU_IF_ARB_TIMEOUT_EN
            else if (expire) begin
               done             = 1'b1;
               m_cmp_d[gnt_q]   = 1'b1;
               m_err_d[gnt_q]   = 1'b1;
               m_rdata_d[gnt_q] = TIMEOUT_DATA;
               state_d          = ST_IDLE;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Slot capture. A pulse to a slot that is still pending is dropped, even
   // when the slot is being completed on the same edge.
   always_comb begin
      pend_d       = pend_q;
      is_wr_d      = is_wr_q;
      slot_addr_d  = slot_addr_q;
      slot_wdata_d = slot_wdata_q;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (!pend_q[i] && (m_cpu_if_read[i] || m_cpu_if_write[i])) begin
            pend_d[i]       = 1'b1;
            is_wr_d[i]      = m_cpu_if_write[i];
            slot_addr_d[i]  = m_cpu_if_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            slot_wdata_d[i] = m_cpu_if_write_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      if (done) begin
         pend_d[gnt_q] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         gnt_q        <= '0;
         pend_q       <= '0;
         is_wr_q      <= '0;
         slot_addr_q  <= '0;
         slot_wdata_q <= '0;
         s_read_q     <= 1'b0;
         s_write_q    <= 1'b0;
         s_addr_q     <= '0;
         s_wdata_q    <= '0;
         m_cmp_q      <= '0;
         m_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         gnt_q        <= gnt_d;
         pend_q       <= pend_d;
         is_wr_q      <= is_wr_d;
         slot_addr_q  <= slot_addr_d;
         slot_wdata_q <= slot_wdata_d;
         s_read_q     <= s_read_d;
         s_write_q    <= s_write_d;
         s_addr_q     <= s_addr_d;
         s_wdata_q    <= s_wdata_d;
         m_cmp_q      <= m_cmp_d;
         m_rdata_q    <= m_rdata_d;
      end
   end

`ifdef CPU_IF_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         m_err_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         m_err_q <= m_err_d;
      end
   end

   assign m_cpu_if_error = m_err_q;
`else
   assign m_cpu_if_error = '0;
`endif

   assign s_cpu_if_read            = s_read_q;
   assign s_cpu_if_write           = s_write_q;
   assign s_cpu_if_address         = s_addr_q;
   assign s_cpu_if_write_data      = s_wdata_q;
   assign m_cpu_if_access_complete = m_cmp_q;
   assign m_cpu_if_read_data       = m_rdata_q;

endmodule

// File: tb/tb_cpu_if_arbiter.sv
// Testbench for cpu_if_arbiter (3 masters). A transaction-level reference model
// predicts every registered output cycle by cycle. Directed scenarios add
// explicit latency, ordering and drop checks, followed by a randomized phase.
// The timeout scenario runs only when CPU_IF_ARB_TIMEOUT_EN is defined.
module tb_cpu_if_arbiter;

   localparam int NM = 3;
   localparam int DW = 32;
   localparam int AW = 30;
   localparam int TO = 8;

   logic              clk;
   logic              reset_n;
   logic [NM-1:0]     m_rd, m_wr;
   logic [NM*DW-1:0]  m_wdata;
   logic [NM*AW-1:0]  m_addr;
   logic [NM*DW-1:0]  m_rdata;
   logic [NM-1:0]     m_cmp, m_err;
   logic              s_rd, s_wr, s_cmp;
   logic [DW-1:0]     s_wdata, s_rdata;
   logic [AW-1:0]     s_addr;

   cpu_if_arbiter #(
      .NUM_MASTERS   (NM),
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .TIMEOUT_CYCLES(TO),
      .TIMEOUT_DATA  (32'hDEAD_BEEF)
   ) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .m_cpu_if_read           (m_rd),
      .m_cpu_if_write          (m_wr),
      .m_cpu_if_write_data     (m_wdata),
      .m_cpu_if_address        (m_addr),
      .m_cpu_if_read_data      (m_rdata),
      .m_cpu_if_access_complete(m_cmp),
      .m_cpu_if_error          (m_err),
      .s_cpu_if_read           (s_rd),
      .s_cpu_if_write          (s_wr),
      .s_cpu_if_write_data     (s_wdata),
      .s_cpu_if_address        (s_addr),
      .s_cpu_if_read_data      (s_rdata),
      .s_cpu_if_access_complete(s_cmp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model state
   int                  cyc;
   bit [NM-1:0]         mpend, mwr;
   logic [AW-1:0]       maddr [NM];
   logic [DW-1:0]       mwd [NM];
   int                  ptr, own, gcyc;
   bit                  mw;
   logic                e_s_rd, e_s_wr;
   logic [AW-1:0]       e_s_addr;
   logic [DW-1:0]       e_s_wd;
   logic [NM-1:0]       e_cmp, e_err;
   logic [NM-1:0][DW-1:0] e_rdata;

   // Slave behaviour and monitor
   int            slat;
   int            force_lat = -1;
   bit            hang      = 0;
   bit            spur      = 0;
   bit            rnd_mode  = 0;
   logic [DW-1:0] next_rdata = '0;
   int            tb_cyc = 0;
   int            last_s_cyc, last_m_cyc, last_scmp_cyc, n_acc, n_cmp;
   logic          last_s_wr;
   logic [DW-1:0] last_s_wd;
   logic [NM-1:0] last_err;
   logic [AW-1:0] acc_q[$];

   task automatic model_reset();
      mpend = '0; mwr = '0; ptr = 0; own = 0; mw = 0; gcyc = 0;
      for (int i = 0; i < NM; i++) begin
         maddr[i] = '0;
         mwd[i]   = '0;
      end
      e_s_rd = 0; e_s_wr = 0; e_s_addr = '0; e_s_wd = '0;
      e_cmp = '0; e_err = '0; e_rdata = '0;
   endtask

   task automatic model_edge();
      int  done_i;
      int  g;
      bit  found;
      done_i = -1;
      cyc++;
      e_s_rd = 0; e_s_wr = 0; e_cmp = '0; e_err = '0;
      if (mw) begin
         if (s_cmp) begin
            e_cmp[own] = 1'b1; e_rdata[own] = s_rdata; done_i = own; mw = 0;
         end
`ifdef CPU_IF_ARB_TIMEOUT_EN
         else if (cyc - gcyc == TO) begin
            e_cmp[own] = 1'b1; e_err[own] = 1'b1; e_rdata[own] = 32'hDEAD_BEEF;
            done_i = own; mw = 0;
         end
`endif
      end else begin
         found = 0;
         for (int k = 0; k < NM; k++) begin
            g = (ptr + k) % NM;
            if (!found && mpend[g]) begin
               found = 1;
               own   = g;
            end
         end
         if (found) begin
            e_s_wr   = mwr[own];
            e_s_rd   = !mwr[own];
            e_s_addr = maddr[own];
            e_s_wd   = mwd[own];
            ptr      = (own + 1) % NM;
            mw       = 1;
            gcyc     = cyc;
            slat     = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
         end
      end
      for (int i = 0; i < NM; i++) begin
         if (!mpend[i] && (m_rd[i] || m_wr[i])) begin
            mpend[i] = 1;
            mwr[i]   = m_wr[i];
            maddr[i] = m_addr[i*AW +: AW];
            mwd[i]   = m_wdata[i*DW +: DW];
         end else if (done_i == i) begin
            mpend[i] = 0;
         end
      end
   endtask

   task automatic compare_all();
      check_eq("s_read",   128'(s_rd),    128'(e_s_rd));
      check_eq("s_write",  128'(s_wr),    128'(e_s_wr));
      check_eq("s_addr",   128'(s_addr),  128'(e_s_addr));
      check_eq("s_wdata",  128'(s_wdata), 128'(e_s_wd));
      check_eq("m_cmp",    128'(m_cmp),   128'(e_cmp));
      check_eq("m_err",    128'(m_err),   128'(e_err));
      check_eq("m_rdata",  128'(m_rdata), 128'(e_rdata));
   endtask

   task automatic monitor();
      tb_cyc++;
      if (s_rd || s_wr) begin
         last_s_cyc = tb_cyc;
         last_s_wr  = s_wr;
         last_s_wd  = s_wdata;
         acc_q.push_back(s_addr);
         n_acc++;
      end
      if (|m_cmp) begin
         last_m_cyc = tb_cyc;
         last_err   = m_err;
         n_cmp++;
      end
   endtask

   task automatic drive_slave();
      s_cmp = 1'b0;
      if (rnd_mode) next_rdata = $urandom;
      s_rdata = next_rdata;
      if (spur) begin
         s_cmp = 1'b1;
         spur  = 0;
      end else if (mw && !hang) begin
         if (slat == 0) begin
            s_cmp         = 1'b1;
            last_scmp_cyc = tb_cyc;
         end else begin
            slat--;
         end
      end else if (!mw && rnd_mode && $urandom_range(0, 9) == 0) begin
         s_cmp = 1'b1;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
      monitor();
      m_rd = '0;
      m_wr = '0;
      drive_slave();
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic req(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
      m_rd[i]              = rd;
      m_wr[i]              = wr;
      m_addr[i*AW +: AW]   = a;
      m_wdata[i*DW +: DW]  = d;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      m_rd = '0; m_wr = '0; s_cmp = 1'b0;
      #2;
      model_reset();
      check_eq("reset_outs", 128'({s_rd, s_wr, s_addr, s_wdata, m_cmp, m_err}), 128'(0));
      check_eq("reset_rdata", 128'(m_rdata), 128'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   int base_acc, base_cmp, drv_cyc;

   initial begin
      reset_n = 1'b1;
      m_rd = '0; m_wr = '0; m_wdata = '0; m_addr = '0;
      s_cmp = 1'b0; s_rdata = '0;
      cyc = 0; n_acc = 0; n_cmp = 0;
      last_s_cyc = 0; last_m_cyc = 0; last_scmp_cyc = 0;
      last_s_wr = 0; last_s_wd = '0; last_err = '0;
      model_reset();
      @(negedge clk);
      apply_reset();

      // All three write together, twice: order 0,1,2 both times.
      force_lat = 0;
      acc_q.delete();
      for (int i = 0; i < NM; i++) req(i, 0, 1, AW'(32'h100 + i), DW'(32'hC0DE_0000 + i));
      cycles(14);
      for (int i = 0; i < NM; i++) req(i, 0, 1, AW'(32'h200 + i), DW'(32'hBEEF_0000 + i));
      cycles(14);
      check_eq("rr_count", 128'(acc_q.size()), 128'(6));
      for (int i = 0; i < 6 && i < acc_q.size(); i++)
         check_eq("rr_order", 128'(acc_q[i]),
                  128'((i < 3) ? (32'h100 + i) : (32'h200 + i - 3)));

      // Single read from master 0 with a 3-cycle slave response.
      force_lat  = 2;
      next_rdata = 32'h1234_5678;
      drv_cyc    = tb_cyc;
      req(0, 1, 0, 30'h10, 32'h0);
      cycles(10);
      check_eq("t1_s_lat", 128'(last_s_cyc - drv_cyc), 128'(2));
      check_eq("t1_is_read", 128'(last_s_wr), 128'(0));
      check_eq("t1_m_lat", 128'(last_m_cyc - last_scmp_cyc), 128'(1));
      check_eq("t1_rdata", 128'(m_rdata[DW-1:0]), 128'(32'h1234_5678));

      // Read+write together (write wins); re-pulse while pending is dropped.
      force_lat = 3;
      base_acc  = n_acc;
      req(1, 1, 1, 30'h33, 32'hA5A5_A5A5);
      cycle();
      req(1, 0, 1, 30'h34, 32'h5A5A_5A5A);
      cycles(10);
      check_eq("rw_acc_cnt", 128'(n_acc - base_acc), 128'(1));
      check_eq("rw_is_write", 128'(last_s_wr), 128'(1));
      check_eq("rw_wdata", 128'(last_s_wd), 128'(32'hA5A5_A5A5));

      // Spurious slave completion while idle.
      base_cmp = n_cmp;
      spur     = 1;
      cycles(4);
      check_eq("spur_no_cmp", 128'(n_cmp - base_cmp), 128'(0));

`ifdef CPU_IF_ARB_TIMEOUT_EN
      // Hung slave: error completion TO cycles after the slave pulse.
      hang = 1;
      req(2, 1, 0, 30'h77, 32'h0);
      cycles(TO + 6);
      check_eq("to_lat", 128'(last_m_cyc - last_s_cyc), 128'(TO));
      check_eq("to_err", 128'(last_err), 128'(3'b100));
      check_eq("to_rdata", 128'(m_rdata[2*DW +: DW]), 128'(32'hDEAD_BEEF));
      hang      = 0;
      force_lat = 1;
      base_cmp  = n_cmp;
      req(2, 1, 0, 30'h78, 32'h0);
      cycles(8);
      check_eq("to_after_cmp", 128'(n_cmp - base_cmp), 128'(1));
      check_eq("to_after_err", 128'(last_err), 128'(0));
`endif

      // Reset in the middle of a WAIT: no completion, pointer back to 0.
      force_lat = 5;
      req(1, 1, 0, 30'h55, 32'h0);
      cycles(3);
      apply_reset();
      base_cmp = n_cmp;
      cycles(6);
      check_eq("rst_no_cmp", 128'(n_cmp - base_cmp), 128'(0));
      acc_q.delete();
      force_lat = 1;
      req(2, 1, 0, 30'h222, 32'h0);
      req(0, 1, 0, 30'h111, 32'h0);
      cycles(10);
      check_eq("rst_first_m0", 128'((acc_q.size() > 0) ? acc_q[0] : '1), 128'(30'h111));

      // Randomized traffic, including dropped re-pulses and spurious completions.
      force_lat = -1;
      rnd_mode  = 1;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NM; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               req(i, 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
               if (!m_rd[i] && !m_wr[i]) m_rd[i] = 1'b1;
            end
         end
         cycle();
      end
      rnd_mode = 0;
      cycles(10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
